// File: rtl/counter_nbit_modulo_updown_if.sv
// Control/status bundle for the modulo up/down counter.
// master drives controls, slave is the counter itself.
interface counter_nbit_modulo_updown_if #(
  parameter int N = 8
);
  logic         clr;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] max_val;
  logic         count_enb;
  logic         dir;
  logic         sat_mode;
  logic         ovf_clr;
  logic [N-1:0] count;
  logic         tc;
  logic         ovf;

  modport master (
    output clr, load, load_val, max_val,
    output count_enb, dir, sat_mode, ovf_clr,
    input  count, tc, ovf
  );

  modport slave (
    input  clr, load, load_val, max_val,
    input  count_enb, dir, sat_mode, ovf_clr,
    output count, tc, ovf
  );
endinterface

// File: rtl/counter_nbit_modulo_updown.sv
// N-bit modulo up/down counter, wrap/saturate, tc pulse, sticky ovf.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module counter_nbit_modulo_updown #(
  parameter int N        = 8,
  parameter int PRESCALE = 4
) (
  input logic                        clk,
  input logic                        reset,
  counter_nbit_modulo_updown_if.slave bus
);

  logic [N-1:0] count_q, count_d;
  logic         tc_q, tc_d;
  logic         ovf_q, ovf_d;
  logic         tick;
  logic         step;
  logic         term;

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  assign tick = (pre_q == PMAX);

  always_comb begin
    pre_d = pre_q;
    if (bus.clr || bus.load) begin
      pre_d = '0;
    end else if (bus.count_enb) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  // Without a prescaler every enabled cycle is a step.
  localparam logic TICK_C = (PRESCALE >= 1);
  assign tick = TICK_C;
`endif

  assign step = bus.count_enb & ~bus.clr & ~bus.load & tick;

  always_comb begin
    count_d = count_q;
    term    = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = (bus.load_val > bus.max_val) ? bus.max_val
                                             : bus.load_val;
    end else if (step) begin
      if (bus.dir) begin
        term = (count_q >= bus.max_val);
        if (count_q < bus.max_val) begin
          count_d = count_q + N'(1);
        end else begin
          count_d = bus.sat_mode ? bus.max_val : '0;
        end
      end else begin
        term = (count_q == '0);
        if (count_q > bus.max_val) begin
          count_d = bus.max_val;
        end else if (count_q != '0) begin
          count_d = count_q - N'(1);
        end else begin
          count_d = bus.sat_mode ? '0 : bus.max_val;
        end
      end
    end
  end

  // Set beats a simultaneous ovf_clr.
  assign tc_d  = term;
  assign ovf_d = term | (ovf_q & ~bus.ovf_clr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_counter_nbit_modulo_updown.sv
// Bench for counter_nbit_modulo_updown: reference model feeds a
// queue of expected outputs, popped after each clock edge.
module tb_counter_nbit_modulo_updown;
  localparam int N = 8;
`ifdef COUNTER_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  counter_nbit_modulo_updown_if #(.N(N)) bus ();

  counter_nbit_modulo_updown #(.N(N), .PRESCALE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int c;
    bit t;
    bit o;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   m_c, m_pre;
  bit   m_t, m_o;
  int   tests = 0;
  int   fails = 0;

  task automatic drive(input bit clr, input bit ld, input int lv,
                       input int mv, input bit enb, input bit d,
                       input bit sat, input bit oc);
    bus.clr       = clr;
    bus.load      = ld;
    bus.load_val  = N'(lv);
    bus.max_val   = N'(mv);
    bus.count_enb = enb;
    bus.dir       = d;
    bus.sat_mode  = sat;
    bus.ovf_clr   = oc;
  endtask

  // Reference model: advance one edge, queue the expectation, clock.
  task automatic cyc();
    int  mv, lv;
    bit  tk, term;
    mv   = int'(bus.max_val);
    lv   = int'(bus.load_val);
    tk   = 1'b0;
    term = 1'b0;
    if (bus.clr) begin
      m_c = 0; m_t = 0; m_pre = 0;
      if (bus.ovf_clr) m_o = 0;
    end else if (bus.load) begin
      m_c = (lv > mv) ? mv : lv; m_t = 0; m_pre = 0;
      if (bus.ovf_clr) m_o = 0;
    end else begin
      if (bus.count_enb) begin
        tk    = (m_pre == P - 1);
        m_pre = tk ? 0 : m_pre + 1;
      end
      if (tk) begin
        if (bus.dir) begin
          term = (m_c >= mv);
          if (m_c < mv) m_c = m_c + 1;
          else m_c = bus.sat_mode ? mv : 0;
        end else begin
          term = (m_c == 0);
          if (m_c > mv) m_c = mv;
          else if (m_c > 0) m_c = m_c - 1;
          else m_c = bus.sat_mode ? 0 : mv;
        end
      end
      m_t = term;
      if (term) m_o = 1;
      else if (bus.ovf_clr) m_o = 0;
    end
    sb.push_back('{m_c, m_t, m_o});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    reset = 1'b0;
    m_c = 0; m_t = 0; m_o = 0; m_pre = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus.count !== 8'd0 || bus.tc !== 1'b0 || bus.ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset: got c=%0d tc=%b ovf=%b want 0 0 0",
               bus.count, bus.tc, bus.ovf);
    end
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_up_wrap();
    int s;
    int wc;
    bit wt, wo;
    drive(0, 0, 0, 9, 1, 1, 0, 0);
    for (int k = 0; k < 12 * P; k++) begin
      cyc();
      e = sb.pop_front();
      s  = (k + 1) / P;
      wc = s % 10;
      wt = ((k + 1) % P == 0) && (s == 10);
      wo = (s >= 10);
      tests++;
      if (bus.count !== N'(e.c) || bus.tc !== e.t || bus.ovf !== e.o ||
          bus.count !== N'(wc) || bus.tc !== wt || bus.ovf !== wo) begin
        fails++;
        $display("FAIL up_wrap cyc%0d: got c=%0d tc=%b ovf=%b want c=%0d tc=%b ovf=%b",
                 k, bus.count, bus.tc, bus.ovf, wc, wt, wo);
      end
    end
  endtask

  task automatic test_down_sat();
    int tcs;
    bit bad;
    tcs = 0;
    bad = 0;
    drive(0, 1, 3, 9, 0, 0, 1, 0);
    cyc();
    e = sb.pop_front();
    tests++;
    if (bus.count !== 8'd3 || bus.tc !== 1'b0 || e.c != 3) begin
      fails++;
      $display("FAIL down_load: got c=%0d tc=%b want 3 0", bus.count, bus.tc);
    end
    drive(0, 0, 0, 9, 1, 0, 1, 0);
    for (int k = 0; k < 6 * P; k++) begin
      cyc();
      e = sb.pop_front();
      if (bus.tc === 1'b1) tcs++;
      if (bus.count === 8'hFF) bad = 1;
      tests++;
      if (bus.count !== N'(e.c) || bus.tc !== e.t || bus.ovf !== e.o) begin
        fails++;
        $display("FAIL down_sat cyc%0d: got c=%0d tc=%b ovf=%b want c=%0d tc=%b ovf=%b",
                 k, bus.count, bus.tc, bus.ovf, e.c, e.t, e.o);
      end
    end
    tests++;
    if (tcs != 3 || bad || bus.count !== 8'd0) begin
      fails++;
      $display("FAIL down_sat_end: got tc_pulses=%0d c=%0d hit255=%b want 3 0 0",
               tcs, bus.count, bad);
    end
  endtask

  task automatic test_priority();
    int want[3];
    want = '{0, 5, 50};
    drive(0, 1, 7, 60, 0, 1, 0, 0);
    cyc();
    void'(sb.pop_front());
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: drive(1, 1, 5, 60, 1, 1, 0, 0);
        1: drive(0, 1, 5, 60, 0, 1, 0, 0);
        default: drive(0, 1, 200, 50, 0, 1, 0, 0);
      endcase
      cyc();
      e = sb.pop_front();
      tests++;
      if (bus.count !== N'(e.c) || bus.tc !== 1'b0 ||
          bus.count !== N'(want[k]) || bus.ovf !== e.o) begin
        fails++;
        $display("FAIL priority%0d: got c=%0d tc=%b want c=%0d tc=0",
                 k, bus.count, bus.tc, want[k]);
      end
    end
  endtask

  task automatic test_runtime_max();
    for (int d = 1; d >= 0; d--) begin
      drive(0, 1, 40, 60, 0, 1, 0, 0);
      cyc();
      void'(sb.pop_front());
      drive(0, 0, 0, 20, 1, d[0], 0, 0);
      for (int k = 0; k < P; k++) begin
        cyc();
        e = sb.pop_front();
      end
      tests++;
      if (bus.count !== N'(e.c) || bus.tc !== e.t || bus.ovf !== e.o ||
          bus.count !== (d ? 8'd0 : 8'd20) || bus.tc !== d[0]) begin
        fails++;
        $display("FAIL runtime_max dir=%0d: got c=%0d tc=%b want c=%0d tc=%0d",
                 d, bus.count, bus.tc, d ? 0 : 20, d);
      end
    end
  endtask

  task automatic test_ovf();
    drive(0, 0, 0, 20, 0, 1, 0, 1);
    cyc();
    e = sb.pop_front();
    tests++;
    if (bus.ovf !== 1'b0 || e.o != 0) begin
      fails++;
      $display("FAIL ovf_clr: got ovf=%b want 0", bus.ovf);
    end
    drive(0, 1, 0, 0, 0, 1, 0, 0);
    cyc();
    void'(sb.pop_front());
    drive(0, 0, 0, 0, 1, 1, 0, 1);
    for (int k = 0; k < P; k++) begin
      cyc();
      e = sb.pop_front();
    end
    tests++;
    if (bus.ovf !== 1'b1 || bus.tc !== 1'b1 || bus.count !== 8'd0 ||
        bus.ovf !== e.o) begin
      fails++;
      $display("FAIL ovf_set_wins: got ovf=%b tc=%b c=%0d want 1 1 0",
               bus.ovf, bus.tc, bus.count);
    end
  endtask

  task automatic test_back_to_back();
    int tcs;
    tcs = 0;
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    for (int k = 0; k < 4 * P; k++) begin
      bus.dir = k[0];
      cyc();
      e = sb.pop_front();
      if (bus.tc === 1'b1) tcs++;
      tests++;
      if (bus.count !== N'(e.c) || bus.tc !== e.t || bus.ovf !== e.o) begin
        fails++;
        $display("FAIL b2b cyc%0d: got c=%0d tc=%b want c=%0d tc=%b",
                 k, bus.count, bus.tc, e.c, e.t);
      end
    end
    tests++;
    if (tcs != 4 || bus.count !== 8'd0) begin
      fails++;
      $display("FAIL b2b_total: got tc_pulses=%0d c=%0d want 4 0",
               tcs, bus.count);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 255, 0, 1, 0, 0);
    cyc();
    void'(sb.pop_front());
    drive(0, 0, 0, 255, 1, 1, 0, 0);
    for (int k = 0; k < 3 * P; k++) begin
      cyc();
      e = sb.pop_front();
    end
    tests++;
    if (bus.count !== 8'd3 || bus.count !== N'(e.c)) begin
      fails++;
      $display("FAIL pre_reset: got c=%0d want 3", bus.count);
    end
    #2 reset = 1'b0;
    #1;
    m_c = 0; m_t = 0; m_o = 0; m_pre = 0;
    tests++;
    if (bus.count !== 8'd0 || bus.tc !== 1'b0 || bus.ovf !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got c=%0d tc=%b ovf=%b want 0 0 0",
               bus.count, bus.tc, bus.ovf);
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    for (int k = 0; k < P; k++) begin
      cyc();
      e = sb.pop_front();
      tests++;
      if (bus.count !== N'(e.c) || bus.tc !== e.t || bus.ovf !== e.o ||
          bus.count !== ((k == P - 1) ? 8'd1 : 8'd0)) begin
        fails++;
        $display("FAIL post_reset cyc%0d: got c=%0d want c=%0d",
                 k, bus.count, (k == P - 1) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_priority();
    test_runtime_max();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_nbit_modulo_updown.md
Name: counter_nbit_modulo_updown

Overview:
- Parametrised N-bit counter with a programmable modulo, up/down direction, synchronous load/clear, and wrap or saturate mode.
- Produces a registered terminal-count pulse and a sticky overflow flag.
- Generalises the team's free-running N-bit enable counter for timers, baud/tick generators and event counters that need a runtime-selectable period.

Parameters:
- N, 8, counter width in bits (N >= 2).
- PRESCALE, 4, number of qualifying enabled cycles per count step. Used only when COUNTER_PRESCALE_EN is defined; must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of count.
- load  input  1  synchronous load of load_val.
- load_val  input  N  value to load.
- max_val  input  N  terminal value; the count range is 0..max_val.
- count_enb  input  1  count enable.
- dir  input  1  1 = count up, 0 = count down.
- sat_mode  input  1  1 = saturate at the limit, 0 = wrap.
- ovf_clr  input  1  clears the ovf sticky flag.
- count  output  N  current count (registered).
- tc  output  1  terminal-count pulse (registered).
- ovf  output  1  sticky overflow flag (registered).

Behaviour:
- Reset (reset=0, asynchronous): count=0, tc=0, ovf=0, prescaler=0. The reset state holds while reset is low. Reset asserted mid-count aborts the count immediately.
- Priority at each rising clk edge: clr > load > count step. count, tc and ovf all update on the same edge.
- clr=1: count<=0, tc<=0, prescaler<=0. ovf is unaffected by clr.
- load=1 (with clr=0):
  - count<=min(load_val, max_val); an out-of-range load clamps to max_val.
  - tc<=0, prescaler<=0.
- Step condition: count_enb=1, clr=0, load=0, and the prescale tick is true. Without the macro, the prescale tick is always 1.
- Up step (dir=1):
  - If count < max_val: count<=count+1.
  - Else (count >= max_val, which also covers max_val lowered below count at runtime), wrap mode: count<=0.
  - Else, saturate mode: count<=max_val, i.e. hold or pull down to the limit.
- Down step (dir=0):
  - If count > max_val: count<=max_val.
  - Else if count > 0: count<=count-1.
  - Else (count==0), wrap mode: count<=max_val; saturate mode: count holds at 0.
- Terminal event: a step taken from the limit. The limit is count >= max_val for up, count==0 for down. A terminal event applies in both modes.
- tc<=1 on the edge that executes a terminal event, and 0 on every other edge. tc is a single-cycle pulse per event and stays high on back-to-back events.
- ovf<=1 on any terminal event. Otherwise ovf_clr=1 gives ovf<=0. Set wins over a simultaneous ovf_clr.
- max_val=0:
  - count stays 0.
  - Every step is a terminal event, so tc is high on each stepping cycle in either direction.
- Direction may change on any cycle. The next step uses the new dir with no extra latency.
- Latency: count, tc and ovf reflect a step one clock after the sampling edge. There is no combinational path from inputs to outputs.
- All arithmetic is N-bit unsigned. No intermediate value exceeds N bits.

Optional Feature:
- Macro: COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescaler of ceil(log2(PRESCALE)) bits (minimum 1) counts cycles where count_enb=1 and clr=load=0.
  - The tick is true when prescaler==PRESCALE-1; on that cycle the prescaler returns to 0, otherwise it increments.
  - count_enb=0 freezes the prescaler.
  - clr, load or reset zero the prescaler.
  - PRESCALE=1 is identical to the undefined case.
- Undefined: no prescaler logic exists, the tick is constant 1, and every enabled cycle is a step.

Test Plan:
- Up wrap: N=8, max_val=9, dir=1, sat_mode=0, count_enb=1 for 12 cycles after reset → count 1..9,0,1,2. tc high only on the edge that returns count to 0. ovf=1 from that edge onward.
- Down saturate: load_val=3, load pulse, then dir=0, sat_mode=1, enb for 6 cycles → count 3,2,1,0,0,0,0. tc high on each of the last 3 edges. Count never goes to 255.
- Priority: clr=1, load=1, load_val=5, count_enb=1 on the same cycle with count=7 → count=0, tc=0. Next cycle load=1 only → count=5. load_val=200 with max_val=50 → count=50.
- Runtime max_val change: count=40, max_val changed to 20, dir=1, wrap mode → next step count=0 and tc=1. With dir=0 instead → count=20 and tc=0.
- ovf control: ovf=1, ovf_clr=1 alone → ovf=0 next edge. ovf_clr=1 coincident with a terminal event → ovf stays 1.
- Reset mid-count plus prescale: COUNTER_PRESCALE_EN defined, PRESCALE=4, max_val=255, enb held → count increments every 4th cycle. Assert reset asynchronously at count=3 → count=0, tc=0, ovf=0 without waiting for clk. After release, the first increment comes 4 enabled cycles later.
